fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_unit_ibuf_2entry.sv | 57 +++++
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit.
package fetch_unit_pkg;

  // Fetch state machine encodings
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_t;

  // Instruction buffer geometry
  localparam int IBUF_DEPTH = 2;
  localparam int IBUF_CNT_W = $clog2(IBUF_DEPTH + 1);
  localparam int IBUF_W     = 16;

  // Address fetched first after reset
  localparam logic [7:0] RESET_PC = 8'h00;

  // Transfer counter ceiling
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/fetch_unit_ibuf_2entry.sv
// Two-deep {pc, word} instruction buffer. Entry 0 is always the head, so a
// pop shifts entry 1 down and a push writes the first free slot after that
// shift. Flush only clears the occupancy; stale data is never exposed as valid.
module ibuf_2entry
  import fetch_unit_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [IBUF_W-1:0]     i_push_data,
  input  logic                  i_pop,
  input  logic                  i_flush,
  output logic [IBUF_W-1:0]     o_head,
  output logic [IBUF_CNT_W-1:0] o_count
);

  logic [IBUF_W-1:0]     r_entry [IBUF_DEPTH];
  logic [IBUF_W-1:0]     w_shift_src [IBUF_DEPTH];
  logic [IBUF_CNT_W-1:0] r_count;
  logic [IBUF_CNT_W-1:0] w_wr_idx;

  // Source each entry takes when the head is popped (last entry keeps its value)
  for (genvar gi = 0; gi < IBUF_DEPTH; gi++) begin : g_shift
    if (gi < IBUF_DEPTH - 1) begin : g_mid
      assign w_shift_src[gi] = r_entry[gi + 1];
    end else begin : g_last
      assign w_shift_src[gi] = r_entry[gi];
    end
  end

  // A push lands after the shift caused by a simultaneous pop
  assign w_wr_idx = r_count - {{(IBUF_CNT_W-1){1'b0}}, i_pop};

  // Entry storage: shift on pop, write tail on push
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < IBUF_DEPTH; i++) r_entry[i] <= '0;
    end else if (!i_flush) begin
      for (int i = 0; i < IBUF_DEPTH; i++) begin
        if (i_push && (w_wr_idx == IBUF_CNT_W'(i))) r_entry[i] <= i_push_data;
        else if (i_pop)                              r_entry[i] <= w_shift_src[i];
      end
    end
  end

  // Occupancy tracking; flush wins over push and pop
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        r_count <= '0;
    else if (i_flush) r_count <= '0;
    else              r_count <= r_count + {{(IBUF_CNT_W-1){1'b0}}, i_push}
                                         - {{(IBUF_CNT_W-1){1'b0}}, i_pop};
  end

  assign o_head  = r_entry[0];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC, one-cycle memory response tracking,
// credit-based issue into a 2-entry buffer, run/halt control, transfer count.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  output logic [7:0]  imem_addr,
  output logic        imem_rd,
  input  logic [7:0]  imem_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  instr_out,
  output logic [7:0]  instr_pc,
  input  logic        redirect,
  input  logic [7:0]  redirect_pc,
  input  logic        halt,
  output logic        halted,
  output logic [15:0] fetch_count
);

  logic [7:0]            r_fetch_pc;
  logic                  r_pending;
  logic [7:0]            r_pending_pc;
  fetch_state_t          r_state;
  logic [15:0]           r_fetch_count;

  logic [IBUF_W-1:0]     w_head;
  logic [IBUF_CNT_W-1:0] w_occupancy;
  logic                  w_transfer;
  logic                  w_push;
  logic [2:0]            w_used;
  logic [2:0]            w_avail;
  logic                  w_issue;

  // Slots already spoken for versus slots available this cycle; a transfer
  // frees its slot on the same edge, so it counts as credit immediately.
  assign w_used     = {1'b0, w_occupancy} + {2'b00, r_pending};
  assign w_avail    = 3'(IBUF_DEPTH) + {2'b00, w_transfer};
  assign w_transfer = instr_valid && instr_ready;
  assign w_issue    = (r_state == ST_RUN) && !halt && !redirect && (w_avail > w_used);
  // A redirect discards the response that arrives on its edge
  assign w_push     = r_pending && !redirect;

  ibuf_2entry u_ibuf (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data ({r_pending_pc, imem_data}),
    .i_pop       (w_transfer),
    .i_flush     (redirect),
    .o_head      (w_head),
    .o_count     (w_occupancy)
  );

  // PC advance on issue, reload on redirect; track the single outstanding fetch
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fetch_pc   <= RESET_PC;
      r_pending    <= 1'b0;
      r_pending_pc <= 8'h00;
    end else begin
      if (redirect)     r_fetch_pc <= redirect_pc;
      else if (w_issue) r_fetch_pc <= r_fetch_pc + 8'h01;
      // w_issue is already low during a redirect, which clears pending
      r_pending <= w_issue;
      if (w_issue) r_pending_pc <= r_fetch_pc;
    end
  end

  // Run/halt control; a redirect edge leaves the state untouched
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else if (!redirect) begin
      case (r_state)
        ST_RUN:    if (halt)  r_state <= ST_HALTED;
        ST_HALTED: if (!halt) r_state <= ST_RUN;
        default:              r_state <= ST_RUN;
      endcase
    end
  end

  // Saturating count of instructions handed to decode
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                       r_fetch_count <= 16'h0000;
    else if (w_transfer && r_fetch_count != COUNT_MAX) r_fetch_count <= r_fetch_count + 16'h0001;
  end

  assign imem_addr   = r_fetch_pc;
  assign imem_rd     = w_issue;
  assign instr_valid = (w_occupancy != '0);
  assign instr_out   = w_head[7:0];
  assign instr_pc    = w_head[15:8];
  assign halted      = (r_state == ST_HALTED) && !r_pending;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a one-cycle-latency memory model.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  imem_addr;
  logic        imem_rd;
  logic [7:0]  imem_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_out;
  logic [7:0]  instr_pc;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        halt;
  logic        halted;
  logic [15:0] fetch_count;

  logic [7:0] mem [256];
  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clock       (clock),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_rd     (imem_rd),
    .imem_data   (imem_data),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  always #5 clock = ~clock;

  // Memory answers one clock after the address is presented
  always @(posedge clock) imem_data <= mem[imem_addr];

  function automatic logic [7:0] exp_word(input logic [7:0] pc);
    if (pc < 8'd3) return 8'((pc + 8'd1) << 4);
    return pc ^ 8'h5A;
  endfunction

  task automatic reset_dut(input logic rdy);
    @(negedge clock);
    reset = 1'b1; redirect = 1'b0; redirect_pc = 8'h00; halt = 1'b0; instr_ready = rdy;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    checks++; if (instr_out !== 8'h00) begin errors++; $display("FAIL reset_out got %h want 00", instr_out); end
    checks++; if (instr_pc !== 8'h00) begin errors++; $display("FAIL reset_pc got %h want 00", instr_pc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", imem_addr); end
    checks++; if (fetch_count !== 16'h0000) begin errors++; $display("FAIL reset_count got %h want 0000", fetch_count); end
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if (imem_rd !== 1'b1) begin errors++; $display("FAIL reset_first_rd got %b want 1", imem_rd); end
    $display("test_reset done");
  endtask

  task automatic test_stream;
    reset_dut(1'b1);
    @(negedge clock);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_edge1_valid got %b want 0", instr_valid); end
    for (int t = 0; t < 3; t++) begin
      @(negedge clock);
      checks++; if ({instr_valid, instr_pc, instr_out} !== {1'b1, 8'(t), exp_word(8'(t))}) begin
        errors++; $display("FAIL stream_xfer%0d got v=%b pc=%h w=%h want v=1 pc=%h w=%h", t, instr_valid, instr_pc, instr_out, 8'(t), exp_word(8'(t)));
      end
      $display("stream transfer pc=%h word=%h", instr_pc, instr_out);
    end
    checks++; if (fetch_count !== 16'd2) begin errors++; $display("FAIL stream_count got %0d want 2", fetch_count); end
  endtask

  task automatic test_backpressure;
    reset_dut(1'b0);
    @(negedge clock);
    checks++; if (imem_rd !== 1'b1) begin errors++; $display("FAIL bp_rd_cycle1 got %b want 1", imem_rd); end
    for (int k = 2; k <= 6; k++) begin
      @(negedge clock);
      checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL bp_rd_cycle%0d got %b want 0", k, imem_rd); end
    end
    checks++; if (imem_addr !== 8'h02) begin errors++; $display("FAIL bp_addr got %h want 02", imem_addr); end
    instr_ready = 1'b1;
    #1;
    for (int t = 0; t < 4; t++) begin
      checks++; if ({instr_valid, instr_pc, instr_out} !== {1'b1, 8'(t), exp_word(8'(t))}) begin
        errors++; $display("FAIL bp_xfer%0d got v=%b pc=%h w=%h want v=1 pc=%h w=%h", t, instr_valid, instr_pc, instr_out, 8'(t), exp_word(8'(t)));
      end
      $display("bp transfer pc=%h word=%h", instr_pc, instr_out);
      @(negedge clock);
    end
    checks++; if (fetch_count !== 16'd4) begin errors++; $display("FAIL bp_count got %0d want 4", fetch_count); end
  endtask

  task automatic test_redirect;
    reset_dut(1'b1);
    repeat (4) @(negedge clock);
    redirect = 1'b1; redirect_pc = 8'h40;
    #1;
    checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL redir_rd_during got %b want 0", imem_rd); end
    @(negedge clock);
    redirect = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_valid_drop got %b want 0", instr_valid); end
    checks++; if (fetch_count !== 16'd3) begin errors++; $display("FAIL redir_count got %0d want 3", fetch_count); end
    checks++; if ({imem_rd, imem_addr} !== {1'b1, 8'h40}) begin errors++; $display("FAIL redir_issue got rd=%b addr=%h want rd=1 addr=40", imem_rd, imem_addr); end
    @(negedge clock);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_stale got v=%b pc=%h want v=0", instr_valid, instr_pc); end
    for (int t = 0; t < 2; t++) begin
      @(negedge clock);
      checks++; if ({instr_valid, instr_pc, instr_out} !== {1'b1, 8'(8'h40 + t), exp_word(8'(8'h40 + t))}) begin
        errors++; $display("FAIL redir_xfer%0d got v=%b pc=%h w=%h want v=1 pc=%h", t, instr_valid, instr_pc, instr_out, 8'(8'h40 + t));
      end
      $display("redirect transfer pc=%h word=%h", instr_pc, instr_out);
    end
  endtask

  task automatic test_halt;
    reset_dut(1'b1);
    repeat (2) @(negedge clock);
    halt = 1'b1;
    #1;
    checks++; if ({imem_rd, halted} !== 2'b00) begin errors++; $display("FAIL halt_enter got rd=%b halted=%b want 0 0", imem_rd, halted); end
    @(negedge clock);
    checks++; if ({instr_valid, instr_pc, halted, imem_rd} !== {1'b1, 8'h01, 1'b1, 1'b0}) begin
      errors++; $display("FAIL halt_drain got v=%b pc=%h halted=%b rd=%b want v=1 pc=01 halted=1 rd=0", instr_valid, instr_pc, halted, imem_rd);
    end
    @(negedge clock);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL halt_empty got %b want 0", instr_valid); end
    repeat (2) @(negedge clock);
    checks++; if ({imem_rd, imem_addr} !== {1'b0, 8'h02}) begin errors++; $display("FAIL halt_hold got rd=%b addr=%h want rd=0 addr=02", imem_rd, imem_addr); end
    halt = 1'b0;
    @(negedge clock);
    checks++; if ({halted, imem_rd, imem_addr} !== {1'b0, 1'b1, 8'h02}) begin
      errors++; $display("FAIL halt_resume got halted=%b rd=%b addr=%h want 0 1 02", halted, imem_rd, imem_addr);
    end
    repeat (2) @(negedge clock);
    checks++; if ({instr_valid, instr_pc} !== {1'b1, 8'h02}) begin errors++; $display("FAIL halt_next got v=%b pc=%h want v=1 pc=02", instr_valid, instr_pc); end
  endtask

  task automatic test_wrap;
    logic [7:0] exp_pc;
    int bad;
    int cyc;
    exp_pc = 8'h00; bad = 0; cyc = 0;
    reset_dut(1'b1);
    while (cyc < 70000) begin
      @(negedge clock);
      cyc++;
      if (fetch_count == 16'hFFFE) break;
      if (instr_valid) begin
        if (instr_pc !== exp_pc || instr_out !== exp_word(exp_pc)) bad++;
        exp_pc = exp_pc + 8'h01;
      end
    end
    checks++; if (cyc >= 70000) begin errors++; $display("FAIL wrap_timeout got count=%h want FFFE", fetch_count); end
    checks++; if (bad != 0) begin errors++; $display("FAIL wrap_order got %0d bad transfers want 0", bad); end
    instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 8'hFF;
    @(negedge clock);
    redirect = 1'b0; instr_ready = 1'b1;
    #1;
    checks++; if ({imem_rd, imem_addr, fetch_count} !== {1'b1, 8'hFF, 16'hFFFE}) begin
      errors++; $display("FAIL wrap_ff got rd=%b addr=%h cnt=%h want 1 FF FFFE", imem_rd, imem_addr, fetch_count);
    end
    @(negedge clock);
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL wrap_addr got %h want 00", imem_addr); end
    @(negedge clock);
    checks++; if ({instr_valid, instr_pc, fetch_count} !== {1'b1, 8'hFF, 16'hFFFE}) begin
      errors++; $display("FAIL wrap_head_ff got v=%b pc=%h cnt=%h want 1 FF FFFE", instr_valid, instr_pc, fetch_count);
    end
    @(negedge clock);
    checks++; if ({instr_valid, instr_pc, fetch_count} !== {1'b1, 8'h00, 16'hFFFF}) begin
      errors++; $display("FAIL wrap_head_00 got v=%b pc=%h cnt=%h want 1 00 FFFF", instr_valid, instr_pc, fetch_count);
    end
    @(negedge clock);
    checks++; if (fetch_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_saturate got %h want FFFF", fetch_count); end
  endtask

  task automatic test_reset_midstream;
    reset_dut(1'b1);
    repeat (3) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    checks++; if ({instr_valid, instr_out, instr_pc, imem_addr, halted} !== {1'b0, 8'h00, 8'h00, 8'h00, 1'b0}) begin
      errors++; $display("FAIL mid_reset_outs got v=%b w=%h pc=%h addr=%h halted=%b want all zero", instr_valid, instr_out, instr_pc, imem_addr, halted);
    end
    checks++; if (fetch_count !== 16'h0000) begin errors++; $display("FAIL mid_reset_count got %h want 0000", fetch_count); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if ({imem_rd, imem_addr} !== {1'b1, 8'h00}) begin errors++; $display("FAIL mid_restart got rd=%b addr=%h want 1 00", imem_rd, imem_addr); end
    @(negedge clock);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mid_discard got v=%b pc=%h want v=0", instr_valid, instr_pc); end
    @(negedge clock);
    checks++; if ({instr_valid, instr_pc, instr_out} !== {1'b1, 8'h00, 8'h10}) begin
      errors++; $display("FAIL mid_first got v=%b pc=%h w=%h want 1 00 10", instr_valid, instr_pc, instr_out);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = exp_word(8'(i));
    reset = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'h00; halt = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_reset_midstream();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
